// File: rtl/scaler_stage_monitor_pkg.sv
// Shared types for the timer scaler-stage monitor.
// Holds the window FSM states, strobe letters and a saturating adder.
package scaler_stage_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  typedef enum logic [1:0] {
    LT_NONE,
    LT_A,
    LT_B
  } letter_t;

  function automatic logic [1:0] sat_add(
    input logic [1:0] v,
    input logic [1:0] n
  );
    logic [2:0] s;
    s = {1'b0, v} + {1'b0, n};
    return (s > 3'd3) ? 2'd3 : s[1:0];
  endfunction

endpackage

// File: rtl/scaler_stage_monitor_edge.sv
// Single-input register with rise/fall strobes.
// Strobes compare the registered value against its previous sample.
module edge_detect_reg (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/scaler_stage_monitor.sv
// Passive observer of the scaler stage: checks one FS01 toggle and
// one alternating F01A/F01B strobe per P01 pulse, reports lock/errors.
module scaler_stage_monitor
  import scaler_stage_monitor_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SETTLE   = 3,
  parameter int LOCK_CNT = 4
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             P01,
  input  logic             F01A,
  input  logic             F01B,
  input  logic             FS01,
  input  logic             FS01_,
  output logic [CNT_W-1:0] P01_CNT,
  output logic [CNT_W-1:0] FS01_CNT,
  output logic             LOCKED,
  output logic             SEQ_ERR,
  output logic             COMP_ERR
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOCK_CNT + 1);

  logic p01_q, p01_rise, p01_fall;
  logic a_q, a_rise, a_fall;
  logic b_q, b_rise, b_fall;
  logic fs_q, fs_rise, fs_fall;
  logic fs_n_q;

  state_t        state, state_nx;
  logic [SW-1:0] settle_ctr;
  logic [1:0]    tog_ctr, stb_ctr;
  letter_t       cur_ltr, last_ltr, win_ltr;
  logic [LW-1:0] clean_ctr, clean_inc;

  logic start_win, do_check, cnt_en;
  logic ltr_ok, seq_bad, comp_bad;

  edge_detect_reg u_p01 (
    .clk(SIM_CLK), .rst(SIM_RST), .d(P01),
    .q(p01_q), .rise(p01_rise), .fall(p01_fall)
  );
  edge_detect_reg u_a (
    .clk(SIM_CLK), .rst(SIM_RST), .d(F01A),
    .q(a_q), .rise(a_rise), .fall(a_fall)
  );
  edge_detect_reg u_b (
    .clk(SIM_CLK), .rst(SIM_RST), .d(F01B),
    .q(b_q), .rise(b_rise), .fall(b_fall)
  );
  edge_detect_reg u_fs (
    .clk(SIM_CLK), .rst(SIM_RST), .d(FS01),
    .q(fs_q), .rise(fs_rise), .fall(fs_fall)
  );

  logic unused_sig;
  assign unused_sig = ^{p01_q, a_q, a_fall, b_q, b_fall};

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state  <= ST_IDLE;
      fs_n_q <= 1'b0;
    end else begin
      state  <= state_nx;
      fs_n_q <= FS01_;
    end
  end

  // A rise during CHECK opens the next window rather than losing it.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (p01_rise) state_nx = ST_PULSE;
      ST_PULSE:  if (p01_fall) state_nx = ST_SETTLE;
      ST_SETTLE: begin
        if (p01_rise)
          state_nx = ST_PULSE;
        else if (settle_ctr <= SW'(1))
          state_nx = ST_CHECK;
      end
      ST_CHECK:  state_nx = p01_rise ? ST_PULSE : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    start_win = (state_nx == ST_PULSE) && (state != ST_PULSE);
    do_check  = (state == ST_CHECK) ||
                ((state == ST_SETTLE) && p01_rise);
    cnt_en    = start_win || (state == ST_PULSE) ||
                (state == ST_SETTLE);
    win_ltr   = (stb_ctr == 2'd1) ? cur_ltr : LT_NONE;
    ltr_ok    = (last_ltr == LT_NONE) || (win_ltr != last_ltr);
    seq_bad   = (tog_ctr != 2'd1) || (stb_ctr != 2'd1) || !ltr_ok;
    comp_bad  = (fs_q == fs_n_q);
    clean_inc = (clean_ctr == LW'(LOCK_CNT)) ?
                clean_ctr : clean_ctr + LW'(1);
  end

  // Edges in the opening cycle belong to the new window.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      tog_ctr    <= 2'd0;
      stb_ctr    <= 2'd0;
      cur_ltr    <= LT_NONE;
      settle_ctr <= '0;
    end else begin
      if (cnt_en) begin
        tog_ctr <= sat_add(start_win ? 2'd0 : tog_ctr,
                           {1'b0, fs_rise | fs_fall});
        stb_ctr <= sat_add(start_win ? 2'd0 : stb_ctr,
                           {1'b0, a_rise} + {1'b0, b_rise});
        if (b_rise)
          cur_ltr <= LT_B;
        else if (a_rise)
          cur_ltr <= LT_A;
        else if (start_win)
          cur_ltr <= LT_NONE;
      end
      if ((state == ST_PULSE) && p01_fall)
        settle_ctr <= SW'(SETTLE);
      else if ((state == ST_SETTLE) && (settle_ctr != '0))
        settle_ctr <= settle_ctr - SW'(1);
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      P01_CNT   <= '0;
      FS01_CNT  <= '0;
      LOCKED    <= 1'b0;
      SEQ_ERR   <= 1'b0;
      COMP_ERR  <= 1'b0;
      clean_ctr <= '0;
      last_ltr  <= LT_NONE;
    end else begin
      if (fs_rise)
        FS01_CNT <= FS01_CNT + CNT_W'(1);
      if (do_check) begin
        P01_CNT  <= P01_CNT + CNT_W'(1);
        SEQ_ERR  <= SEQ_ERR | seq_bad;
        COMP_ERR <= COMP_ERR | comp_bad;
        last_ltr <= win_ltr;
        if (seq_bad || comp_bad) begin
          clean_ctr <= '0;
          LOCKED    <= 1'b0;
        end else begin
          clean_ctr <= clean_inc;
          LOCKED    <= (clean_inc == LW'(LOCK_CNT));
        end
      end
    end
  end

endmodule

// File: tb/tb_scaler_stage_monitor.sv
// Bench for scaler_stage_monitor: directed scenarios then random faults,
// checked against a per-pulse rule model.
module tb_scaler_stage_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic p01 = 1'b0;
  logic f01a = 1'b0;
  logic f01b = 1'b0;
  logic fs01 = 1'b0;
  logic fs01_n = 1'b1;

  logic [15:0] p_cnt16, fs_cnt16;
  logic        lk16, se16, ce16;
  logic [3:0]  p_cnt4, fs_cnt4;
  logic        lk4, se4, ce4;

  int checks = 0;
  int errors = 0;

  int exp_p, exp_fs, clean_run, prev_ltr;
  bit exp_lock, exp_seq, exp_comp;
  int nxt_ltr = 1;
  bit fs = 1'b0;

  always #5 clk = ~clk;

  scaler_stage_monitor #(.CNT_W(16)) u_dut (
    .SIM_CLK(clk), .SIM_RST(rst), .P01(p01),
    .F01A(f01a), .F01B(f01b), .FS01(fs01), .FS01_(fs01_n),
    .P01_CNT(p_cnt16), .FS01_CNT(fs_cnt16),
    .LOCKED(lk16), .SEQ_ERR(se16), .COMP_ERR(ce16)
  );

  scaler_stage_monitor #(.CNT_W(4)) u_dut4 (
    .SIM_CLK(clk), .SIM_RST(rst), .P01(p01),
    .F01A(f01a), .F01B(f01b), .FS01(fs01), .FS01_(fs01_n),
    .P01_CNT(p_cnt4), .FS01_CNT(fs_cnt4),
    .LOCKED(lk4), .SEQ_ERR(se4), .COMP_ERR(ce4)
  );

  task automatic chk(input string tag, input string name,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d",
             tag, name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "p01_cnt", 32'(p_cnt16), 32'(exp_p % 65536));
    chk(tag, "fs01_cnt", 32'(fs_cnt16), 32'(exp_fs % 65536));
    chk(tag, "locked", 32'(lk16), 32'(exp_lock));
    chk(tag, "seq_err", 32'(se16), 32'(exp_seq));
    chk(tag, "comp_err", 32'(ce16), 32'(exp_comp));
    chk(tag, "p01_cnt4", 32'(p_cnt4), 32'(exp_p % 16));
    chk(tag, "fs01_cnt4", 32'(fs_cnt4), 32'(exp_fs % 16));
    chk(tag, "locked4", 32'(lk4), 32'(exp_lock));
    chk(tag, "seq_err4", 32'(se4), 32'(exp_seq));
    chk(tag, "comp_err4", 32'(ce4), 32'(exp_comp));
  endtask

  task automatic model_reset();
    exp_p = 0;
    exp_fs = 0;
    clean_run = 0;
    prev_ltr = 0;
    exp_lock = 1'b0;
    exp_seq = 1'b0;
    exp_comp = 1'b0;
  endtask

  task automatic set_fs(input bit v);
    if (!fs && v) exp_fs++;
    fs = v;
    fs01 = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p01 = 1'b0;
    f01a = 1'b0;
    f01b = 1'b0;
    set_fs(1'b0);
    fs01_n = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // mode: 0 normal, 1 repeat last letter, 2 no strobe, 3 both strobes
  task automatic pulse(input int ntog, input int mode, input bit comp,
                       input bit rst_mid, input string tag);
    int nstb = 0;
    int ltr = 0;
    int win;
    bit seq_bad;
    for (int c = 0; c < 8; c++) begin
      p01 = (c < 2);
      f01a = 1'b0;
      f01b = 1'b0;
      if (c == 0) fs01_n = ~fs;
      if (c == 1) begin
        case (mode)
          0: begin ltr = nxt_ltr; nxt_ltr = 3 - nxt_ltr; end
          1: ltr = 3 - nxt_ltr;
          default: ltr = 0;
        endcase
        f01a = (ltr == 1) || (mode == 3);
        f01b = (ltr == 2) || (mode == 3);
        nstb = (mode == 3) ? 2 : ((ltr != 0) ? 1 : 0);
        if (ntog >= 1) set_fs(!fs);
        fs01_n = ~fs;
        if (rst_mid) begin
          #2;
          rst = 1'b1;
          set_fs(1'b0);
          fs01_n = 1'b1;
          model_reset();
          #1;
          check_all({tag, ".async"});
        end
      end
      if (c == 2) begin
        if (ntog == 2) set_fs(!fs);
        fs01_n = comp ? fs : ~fs;
      end
      if (c == 5 && rst_mid) rst = 1'b0;
      @(posedge clk);
      #1;
    end
    if (!rst_mid) begin
      win = (nstb == 1) ? ltr : 0;
      seq_bad = (ntog != 1) || (nstb != 1) ||
                ((prev_ltr != 0) && (win == prev_ltr));
      exp_p++;
      exp_seq = exp_seq | seq_bad;
      exp_comp = exp_comp | comp;
      prev_ltr = win;
      if (seq_bad || comp) clean_run = 0;
      else clean_run++;
      exp_lock = (clean_run >= 4);
    end
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 8; i++) pulse(1, 0, 1'b0, 1'b0, "clean");

    do_reset();
    for (int i = 0; i < 10; i++)
      pulse(1, (i == 5) ? 1 : 0, 1'b0, 1'b0, "alt");

    do_reset();
    for (int i = 0; i < 8; i++)
      pulse(1, 0, (i == 2), 1'b0, "comp");

    pulse(2, 0, 1'b0, 1'b0, "dbl_tog");
    pulse(1, 0, 1'b0, 1'b0, "post_dbl");

    do_reset();
    for (int i = 0; i < 5; i++) pulse(1, 0, 1'b0, 1'b0, "pre_rst");
    pulse(1, 0, 1'b0, 1'b1, "rst_mid");
    pulse(1, 0, 1'b0, 1'b0, "after_rst");

    do_reset();
    for (int i = 0; i < 17; i++) pulse(1, 0, 1'b0, 1'b0, "wrap");

    for (int i = 0; i < 40; i++) begin
      int r_tog, r_mode, nt, md;
      r_tog = int'($urandom % 6);
      r_mode = int'($urandom % 8);
      nt = (r_tog == 0) ? 0 : ((r_tog == 1) ? 2 : 1);
      md = (r_mode < 3) ? r_mode + 1 : 0;
      pulse(nt, md, ($urandom % 8) == 0, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
